// File: rtl/div_arbiter_pkg.sv
// Shared definitions for the two-requester divider arbiter: FSM encoding,
// default widths and the strict status-flag qualifier.
package div_arbiter_pkg;

  localparam int W_DEF   = 10;
  localparam int TMO_DEF = 63;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  // Divider flags float to Z when idle, so only a clean logic 1 counts.
  function automatic logic is_one(input logic x);
    return (x === 1'b1);
  endfunction

endpackage

// File: rtl/div_arbiter_rr_arb2.sv
// Two-way round-robin grant: a lone request always wins, a tie goes to the
// side named by the priority pointer.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       ptr,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = 2'b00;
    if (req == 2'b11) gnt = ptr ? 2'b10 : 2'b01;
    else              gnt = req;
  end

endmodule

// File: rtl/div_arbiter.sv
// Shares one divider between two requesters. The sequence is
// IDLE (ack) -> ISSUE (start) -> WAIT (completion or timeout) -> RESP (done).
module div_arbiter
  import div_arbiter_pkg::*;
#(
  parameter int W   = W_DEF,
  parameter int TMO = TMO_DEF
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         req0,
  input  logic         req1,
  input  logic [W-1:0] a0,
  input  logic [W-1:0] b0,
  input  logic [W-1:0] a1,
  input  logic [W-1:0] b1,
  output logic         ack0,
  output logic         ack1,
  output logic         done0,
  output logic         done1,
  output logic [W-1:0] q_out,
  output logic         dvz_out,
  output logic         ovf_out,
  output logic         tmo_out,
  output logic         arb_busy,
  output logic [W-1:0] div_a,
  output logic [W-1:0] div_b,
  output logic         div_start,
  input  logic         div_busy,
  input  logic         div_valid,
  input  logic         div_dvz,
  input  logic         div_ovf,
  input  logic [W-1:0] div_q,
  output state_t       state_dbg
);

  localparam int CW = (TMO < 1) ? 1 : $clog2(TMO + 1);

  // Handshake: reqN is a level held with stable operands until ackN; ackN is a
  // one-cycle pulse in the IDLE cycle that captures the operands; doneN is a
  // one-cycle pulse qualifying q_out and the error flags, which are 0 otherwise.

  state_t         state, state_nx;
  logic           ptr;
  logic           gid;
  logic [CW-1:0]  cnt;
  logic [CW-1:0]  cnt_inc;
  logic [W-1:0]   q_r;
  logic           dvz_r, ovf_r, tmo_r;
  logic [1:0]     gnt;
  logic           busy1, valid1, dvz1, ovf1;
  logic           complete, tmo_hit, resp, live;

  rr_arb2 u_rr (
    .req ({req1, req0}),
    .ptr (ptr),
    .gnt (gnt)
  );

  assign busy1  = is_one(div_busy);
  assign valid1 = is_one(div_valid);
  assign dvz1   = is_one(div_dvz);
  assign ovf1   = is_one(div_ovf);

  // cnt is zero only in the first WAIT cycle, where the divider has not yet
  // had a chance to raise busy, so completion is ignored there.
  assign cnt_inc  = cnt + CW'(1);
  assign complete = !busy1 && (valid1 || dvz1 || ovf1) && (cnt != '0);
  assign tmo_hit  = (cnt_inc == CW'(TMO));

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:  if (gnt != 2'b00) state_nx = ST_ISSUE;
      ST_ISSUE: state_nx = ST_WAIT;
      ST_WAIT:  if (complete || tmo_hit) state_nx = ST_RESP;
      ST_RESP:  state_nx = ST_IDLE;
      default:  state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= ST_IDLE;
      ptr   <= 1'b0;
      gid   <= 1'b0;
      cnt   <= '0;
      div_a <= '0;
      div_b <= '0;
      q_r   <= '0;
      dvz_r <= 1'b0;
      ovf_r <= 1'b0;
      tmo_r <= 1'b0;
    end else begin
      state <= state_nx;
      case (state)
        ST_IDLE: begin
          if (gnt != 2'b00) begin
            gid   <= gnt[1];
            div_a <= gnt[1] ? a1 : a0;
            div_b <= gnt[1] ? b1 : b0;
          end
        end
        ST_ISSUE: cnt <= '0;
        ST_WAIT: begin
          if (complete) begin
            q_r   <= valid1 ? div_q : '0;
            dvz_r <= dvz1;
            ovf_r <= ovf1;
            tmo_r <= 1'b0;
          end else if (tmo_hit) begin
            q_r   <= '0;
            dvz_r <= 1'b0;
            ovf_r <= 1'b0;
            tmo_r <= 1'b1;
          end else begin
            cnt <= cnt_inc;
          end
        end
        ST_RESP: ptr <= ~gid;
        default: ;
      endcase
    end
  end

  // Outputs are forced quiet while reset is held so an aborted transaction
  // can never leak a done pulse.
  assign live      = ~reset;
  assign resp      = live && (state == ST_RESP);
  assign ack0      = live && (state == ST_IDLE) && gnt[0];
  assign ack1      = live && (state == ST_IDLE) && gnt[1];
  assign done0     = resp && !gid;
  assign done1     = resp && gid;
  assign q_out     = resp ? q_r : '0;
  assign dvz_out   = resp && dvz_r;
  assign ovf_out   = resp && ovf_r;
  assign tmo_out   = resp && tmo_r;
  assign arb_busy  = live && (state != ST_IDLE);
  assign div_start = live && (state == ST_ISSUE);
  assign state_dbg = state;

endmodule

// File: doc/div_arbiter.md
DIV_ARBITER -- requirements
Module: div_arbiter

Interface
REQ-001 Parameter: W, default 10, operand/quotient width matching the shared divider.
REQ-002 Parameter: TMO, default 63, max WAIT cycles before timeout abort.
REQ-003 clock  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  reset is synchronous and active-high.
REQ-005 req0, req1  input  1 each  level request; held high until matching ack.
REQ-006 a0, b0, a1, b1  input  W each  dividend/divisor per requester; stable while req high.
REQ-007 ack0, ack1  output  1 each  one-cycle pulse: operands captured, req may drop.
REQ-008 done0, done1  output  1 each  one-cycle pulse: result valid for that requester.
REQ-009 q_out  output  W  quotient; meaningful only during done pulse, else 0.
REQ-010 dvz_out, ovf_out, tmo_out  output  1 each  error flags qualified by done pulse, else 0.
REQ-011 arb_busy  output  1  high in every state except IDLE.
REQ-012 div_a, div_b  output  W each  operands to divider, held from ISSUE through WAIT.
REQ-013 div_start  output  1  one-cycle start pulse to divider.
REQ-014 div_busy, div_valid, div_dvz, div_ovf  input  1 each  divider status.
REQ-015 div_q  input  W  divider quotient.

Function
REQ-016 FSM states: IDLE, ISSUE, WAIT, RESP; binary encoded.
REQ-017 IDLE: if any req high, choose winner, assert ack of winner that cycle, capture its a/b into div_a/div_b, record grant id, go ISSUE; else stay.
REQ-018 Arbitration: round-robin, 1-bit priority pointer; single request always wins; both high -> pointer side wins.
REQ-019 Pointer updates in RESP to the non-served requester; unchanged otherwise.
REQ-020 ISSUE: div_start=1 for exactly one cycle, clear timeout counter, go WAIT.
REQ-021 WAIT: complete when div_busy==0 and any of div_valid/div_dvz/div_ovf is exactly 1; capture div_q (0 if div_valid not 1), dvz, ovf; go RESP.
REQ-022 Divider status inputs SHALL be treated as 0 unless exactly logic 1 (divider flags float high-Z when inactive).
REQ-023 WAIT: completion not evaluated in the first WAIT cycle (divider busy latency).
REQ-024 WAIT: counter increments each cycle; on reaching TMO without completion set tmo flag, q=0, go RESP.
REQ-025 RESP: assert done of recorded grant id with q_out and flags for one cycle; go IDLE.
REQ-026 Latency: ack in cycle 0, div_start cycle 1, done = completion cycle + 1.
REQ-027 New request in RESP not acked until next IDLE cycle; no back-to-back IDLE bypass.
REQ-028 Requests arriving while arb_busy are held pending (level), never dropped.
REQ-029 ack and done never asserted for both requesters in the same cycle.

Reset
REQ-030 Reset: state IDLE, pointer=0 (req0 priority), counter=0, all outputs 0.
REQ-031 Reset mid-operation aborts transaction with no done pulse; divider reset by shared reset.

Structure
REQ-032 Shared package: state encoding, W and TMO defaults.
REQ-033 One sub-module: rr_arb2 (combinational 2-way round-robin grant from req pair and pointer).
REQ-034 Timeout counter width ceil(log2(TMO+1)).

Verification
REQ-035 req0 with a0=100, b0=7 -> ack0 next edge, div_start 1 cycle later, done0 with q_out=14, flags 0.
REQ-036 req0 and req1 high same cycle after reset -> serve 0 then 1; repeat both -> serve 1 first.
REQ-037 req1 with a1=55, b1=0, divider asserts dvz -> done1, dvz_out=1, q_out=0.
REQ-038 Divider stub never completes -> done after TMO WAIT cycles with tmo_out=1; next request served normally.
REQ-039 reset asserted during WAIT -> next cycle IDLE, arb_busy=0, no done; pointer=0.
REQ-040 req1 asserted during RESP of req0 -> ack1 in following IDLE cycle, no lost request.
